// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared state encoding, default durations and output bundle for the wash sequencer
package wm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HEAT  = 3'd2,
        S_SOAK  = 3'd3,
        S_WASH  = 3'd4,
        S_RINSE = 3'd5,
        S_SPIN  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam int DEF_TW      = 16;
    localparam int DEF_SOAK_T  = 600;
    localparam int DEF_WASH_T  = 1200;
    localparam int DEF_RINSE_T = 600;
    localparam int DEF_SPIN_T  = 300;
    localparam int DEF_FILL_TO = 200;
    localparam int DEF_HEAT_TO = 200;

    typedef struct packed {
        logic water;
        logic heater;
        logic soak;
        logic wash;
        logic rinse;
        logic spin;
        logic busy;
        logic done;
        logic fault;
    } outs_t;

    // The timer expires on the tick seen at zero, so a phase of d ticks loads d-1; zero acts as one tick.
    function automatic int load_count(input int dur);
        return (dur <= 0) ? 0 : dur - 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with tick enable, freeze and expiry flag
module phase_timer #(
    parameter int TW = 16
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          tick_i,
    input  logic          freeze_i,
    output logic          expire_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && !freeze_i && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    assign expire_o = tick_i && !freeze_i && (count_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washing machine cycle sequencer: fill, heat, timed phases, fault and abort
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int TW      = DEF_TW,
    parameter int SOAK_T  = DEF_SOAK_T,
    parameter int WASH_T  = DEF_WASH_T,
    parameter int RINSE_T = DEF_RINSE_T,
    parameter int SPIN_T  = DEF_SPIN_T,
    parameter int FILL_TO = DEF_FILL_TO,
    parameter int HEAT_TO = DEF_HEAT_TO
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic start_i,
    input  logic lid_i,
    input  logic cancel_i,
    input  logic fill_Water_i,
    input  logic heat_Water_i,
    output logic water_Intake_o,
    output logic heater_On_o,
    output logic soak_Operation_o,
    output logic wash_Operation_o,
    output logic rinse_Operation_o,
    output logic spin_Operation_o,
    output logic busy_o,
    output logic cycle_Done_o,
    output logic fault_o
);

    state_t        state_q;
    state_t        state_d;
    outs_t         out_q;
    outs_t         out_d;
    logic          freeze;
    logic          expire;
    logic          load;
    logic [TW-1:0] load_val;

    // Lid only pauses the timed phases; fill and heat keep timing out with the lid open.
    assign freeze = lid_i && (state_q inside {S_SOAK, S_WASH, S_RINSE, S_SPIN});
    assign load   = (state_d != state_q);

    always_comb begin
        case (state_d)
            S_FILL:  load_val = TW'(load_count(FILL_TO));
            S_HEAT:  load_val = TW'(load_count(HEAT_TO));
            S_SOAK:  load_val = TW'(load_count(SOAK_T));
            S_WASH:  load_val = TW'(load_count(WASH_T));
            S_RINSE: load_val = TW'(load_count(RINSE_T));
            S_SPIN:  load_val = TW'(load_count(SPIN_T));
            default: load_val = '0;
        endcase
    end

    phase_timer #(.TW(TW)) u_timer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_i     (tick_i),
        .freeze_i   (freeze),
        .expire_o   (expire)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i && !lid_i && !cancel_i) state_d = S_FILL;
                S_FILL:  if (fill_Water_i) state_d = S_HEAT;
                         else if (expire) state_d = S_FAULT;
                S_HEAT:  if (heat_Water_i) state_d = S_SOAK;
                         else if (expire) state_d = S_FAULT;
                S_SOAK:  if (expire) state_d = S_WASH;
                S_WASH:  if (expire) state_d = S_RINSE;
                S_RINSE: if (expire) state_d = S_SPIN;
                S_SPIN:  if (expire) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    always_comb begin
        out_d        = '0;
        out_d.water  = (state_d == S_FILL);
        out_d.heater = (state_d == S_HEAT);
        out_d.soak   = (state_d == S_SOAK)  && !lid_i;
        out_d.wash   = (state_d == S_WASH)  && !lid_i;
        out_d.rinse  = (state_d == S_RINSE) && !lid_i;
        out_d.spin   = (state_d == S_SPIN)  && !lid_i;
        out_d.busy   = state_d inside {S_FILL, S_HEAT, S_SOAK, S_WASH, S_RINSE, S_SPIN};
        out_d.done   = (state_q == S_SPIN) && (state_d == S_IDLE) && !cancel_i;
        out_d.fault  = (state_d == S_FAULT);
    end

    assign water_Intake_o    = out_q.water;
    assign heater_On_o       = out_q.heater;
    assign soak_Operation_o  = out_q.soak;
    assign wash_Operation_o  = out_q.wash;
    assign rinse_Operation_o = out_q.rinse;
    assign spin_Operation_o  = out_q.spin;
    assign busy_o            = out_q.busy;
    assign cycle_Done_o      = out_q.done;
    assign fault_o           = out_q.fault;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - self-checking bench for wash_sequencer against a phase/ticks-remaining model
module tb_wash_sequencer;

    localparam int P_SOAK = 3, P_WASH = 4, P_RINSE = 2, P_SPIN = 5, P_FILL = 5, P_HEAT = 5;

    logic clk = 1'b0, rst = 1'b1;
    logic tick = 1'b1, start = 1'b0, lid = 1'b0, cancel = 1'b0, fill = 1'b0, heat = 1'b0;
    logic water, heater, soak, wash, rinse, spin, busy, done, fault;
    logic [8:0] obs;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 fill, 2 heat, 3 soak, 4 wash, 5 rinse, 6 spin, 7 fault; rem = ticks still owed.
    int m_ph = 0;
    int m_rem = 0;
    bit m_done = 0;

    wash_sequencer #(
        .TW(8), .SOAK_T(P_SOAK), .WASH_T(P_WASH), .RINSE_T(P_RINSE), .SPIN_T(P_SPIN),
        .FILL_TO(P_FILL), .HEAT_TO(P_HEAT)
    ) dut (
        .clock_i(clk), .reset_i(rst), .tick_i(tick), .start_i(start), .lid_i(lid),
        .cancel_i(cancel), .fill_Water_i(fill), .heat_Water_i(heat),
        .water_Intake_o(water), .heater_On_o(heater), .soak_Operation_o(soak),
        .wash_Operation_o(wash), .rinse_Operation_o(rinse), .spin_Operation_o(spin),
        .busy_o(busy), .cycle_Done_o(done), .fault_o(fault)
    );

    assign obs = {water, heater, soak, wash, rinse, spin, busy, done, fault};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dur(input int p);
        int d;
        case (p)
            1: d = P_FILL;  2: d = P_HEAT;  3: d = P_SOAK;
            4: d = P_WASH;  5: d = P_RINSE; 6: d = P_SPIN;
            default: d = 1;
        endcase
        return (d < 1) ? 1 : d;
    endfunction

    task automatic enter(input int p);
        m_ph  = p;
        m_rem = dur(p);
    endtask

    task automatic model_step();
        m_done = 0;
        if (m_ph != 0 && cancel) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            if (start && !lid && !cancel) enter(1);
        end else if (m_ph == 1 || m_ph == 2) begin
            if ((m_ph == 1) ? fill : heat) enter(m_ph + 1);
            else if (tick) begin
                m_rem--;
                if (m_rem == 0) m_ph = 7;
            end
        end else if (m_ph >= 3 && m_ph <= 6) begin
            if (tick && !lid) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_ph == 6) begin m_ph = 0; m_done = 1; end
                    else enter(m_ph + 1);
                end
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {m_ph == 1, m_ph == 2, m_ph == 3 && !lid, m_ph == 4 && !lid, m_ph == 5 && !lid,
                m_ph == 6 && !lid, m_ph >= 1 && m_ph <= 6, m_done, m_ph == 7};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_until(input int bit_idx, output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (obs[bit_idx] === 1'b1) ok = 1;
        end
    endtask

    task automatic go_idle();
        {start, lid, fill, heat} = '0;
        tick = 1'b1;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 9'b0) begin
            errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0);
        end
        rst = 1'b0;
        m_ph = 0; m_done = 0;
        step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_release got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_normal_cycle();
        int n_soak = 0, n_wash = 0, n_rinse = 0, n_spin = 0, n_done = 0, bad = 0;
        go_idle();
        fill = 1; heat = 1; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 26; i++) begin
            step();
            if (obs !== exp_vec()) bad++;
            n_soak += int'(soak); n_wash += int'(wash); n_rinse += int'(rinse);
            n_spin += int'(spin); n_done += int'(done);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL normal_model cycles_off=%0d want=0", bad); end
        checks++;
        if (n_soak != 3) begin errors++; $display("FAIL soak_len got=%0d want=3", n_soak); end
        checks++;
        if (n_wash != 4) begin errors++; $display("FAIL wash_len got=%0d want=4", n_wash); end
        checks++;
        if (n_rinse != 2) begin errors++; $display("FAIL rinse_len got=%0d want=2", n_rinse); end
        checks++;
        if (n_spin != 5) begin errors++; $display("FAIL spin_len got=%0d want=5", n_spin); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL done_pulses got=%0d want=1", n_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_cycle got=%b want=0", busy); end
    endtask

    task automatic test_lid_pause();
        bit ok;
        int bad = 0, n = 0;
        go_idle();
        fill = 1; heat = 1; start = 1;
        step();
        start = 0;
        run_until(5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lid_reach_wash got=timeout want=wash"); end
        step(); step();
        lid = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wash !== 1'b0 || obs !== exp_vec()) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL lid_hold cycles_off=%0d want=0", bad); end
        lid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            n++;
            if (rinse === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || n != 2) begin errors++; $display("FAIL lid_resume ticks_to_rinse got=%0d want=2", n); end
    endtask

    task automatic test_fill_timeout();
        bit ok = 0;
        int n = 0, bad = 0;
        go_idle();
        fill = 0; heat = 1; start = 1;
        step();
        start = 0;
        checks++;
        if (water !== 1'b1) begin errors++; $display("FAIL fill_valve got=%b want=1", water); end
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            n++;
            if (fault === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || n != P_FILL) begin errors++; $display("FAIL fill_timeout ticks got=%0d want=%0d", n, P_FILL); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs !== 9'b000000001 || obs !== exp_vec()) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fault_sticky cycles_off=%0d want=0", bad); end
        cancel = 1;
        step();
        cancel = 0;
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL fault_cancel got=%b want=%b", obs, 9'b0); end
    endtask

    task automatic test_cancel_vs_expiry();
        bit ok;
        int bad = 0;
        go_idle();
        fill = 1; heat = 1; start = 1;
        step();
        start = 0;
        run_until(4, ok);
        step();
        cancel = 1;
        step();
        cancel = 0;
        checks++;
        if (!ok || obs !== 9'b0) begin errors++; $display("FAIL cancel_rinse got=%b want=%b", obs, 9'b0); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (spin !== 1'b0 || done !== 1'b0 || obs !== exp_vec()) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL cancel_no_spin cycles_off=%0d want=0", bad); end
    endtask

    task automatic test_start_lid();
        go_idle();
        lid = 1; start = 1; fill = 1; heat = 1;
        step(); step(); step();
        start = 0; lid = 0;
        checks++;
        if (busy !== 1'b0 || obs !== 9'b0) begin errors++; $display("FAIL start_lid got=%b want=%b", obs, 9'b0); end
    endtask

    task automatic test_reset_mid_spin();
        bit ok;
        int bad = 0;
        go_idle();
        fill = 1; heat = 1; start = 1;
        step();
        start = 0;
        run_until(3, ok);
        #2;
        rst = 1;
        #1;
        checks++;
        if (!ok || obs !== 9'b0) begin errors++; $display("FAIL reset_async got=%b want=%b", obs, 9'b0); end
        m_ph = 0; m_done = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs !== 9'b0 || obs !== exp_vec()) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_release_idle cycles_off=%0d want=0", bad); end
    endtask

    task automatic test_random();
        int bad = 0;
        logic [8:0] first_got = '0, first_exp = '0;
        go_idle();
        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom % 4) == 0;
            lid    = ($urandom % 6) == 0;
            cancel = ($urandom % 40) == 0;
            fill   = ($urandom % 4) != 0;
            heat   = ($urandom % 4) != 0;
            tick   = ($urandom % 4) != 0;
            step();
            if (obs !== exp_vec()) begin
                if (bad == 0) begin first_got = obs; first_exp = exp_vec(); end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_model cycles_off=%0d first got=%b want=%b", bad, first_got, first_exp);
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_lid_pause();
        test_fill_timeout();
        test_cancel_vs_expiry();
        test_start_lid();
        test_reset_mid_spin();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
